// File: rtl/ws2812b_fifo_avalon_interface.sv
// Avalon-MM pixel FIFO feeding the WS2812B serializer.
// Adds status, sticky error flags, flush and low-water irq.
module ws2812b_fifo_avalon_interface #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic [31:0]           writedata,
  input  logic                  write,
  input  logic                  read,
  output logic [31:0]           readdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [AW:0]           count_nxt;
  logic [AW:0]           threshold;
  logic                  overflow;
  logic                  underrun;
  logic                  irq_en;
  logic                  full;
  logic                  push;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ctrl_wr;
  logic                  thr_wr;
  logic                  flush;
  logic                  ovf_set;
  logic                  udr_set;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = write && (address == 2'd0);
  assign ctrl_wr = write && (address == 2'd2);
  assign thr_wr  = write && (address == 2'd3);
  assign flush   = ctrl_wr && writedata[0];

  // A flush swallows any pop presented in the same cycle.
  assign pop_ok  = pop && valid && !flush;
  assign push_ok = push && (!full || pop_ok);
  assign ovf_set = push && full && !pop_ok;
  assign udr_set = pop && !valid && !flush;

  assign count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
      irq       <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count_nxt;
      end
      // Setting a sticky flag wins over a W1C clear.
      overflow <= ovf_set ||
        (overflow && !(ctrl_wr && writedata[2]));
      underrun <= udr_set ||
        (underrun && !(ctrl_wr && writedata[3]));
      if (ctrl_wr)
        irq_en <= writedata[4];
      if (thr_wr)
        threshold <= writedata[AW:0];
      irq <= irq_en && (count < threshold);
    end
  end

  assign data_out = valid ? mem[rd_ptr] : '0;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd1: begin
        readdata[0]          = valid;
        readdata[1]          = full;
        readdata[2]          = overflow;
        readdata[3]          = underrun;
        readdata[4]          = irq;
        readdata[8 +: AW+1]  = count;
      end
      2'd2: readdata[4] = irq_en;
      2'd3: readdata[AW:0] = threshold;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_fifo_avalon_interface.sv
// Directed bench for ws2812b_fifo_avalon_interface.
// Vector table plus hand sequences for overflow, full and reset.
module tb_ws2812b_fifo_avalon_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [31:0] readdata;
  logic        pop;
  logic [23:0] data_out;
  logic        valid;
  logic        irq;

  int vecs = 0;
  int miscompares = 0;

  ws2812b_fifo_avalon_interface #(
    .DATA_WIDTH(24),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .writedata(writedata),
    .write(write),
    .read(read),
    .readdata(readdata),
    .pop(pop),
    .data_out(data_out),
    .valid(valid),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        pop;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [23:0] exp_data;
    logic        exp_irq;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic wr, input logic [1:0] addr,
                     input logic [31:0] wd, input logic p,
                     input logic [1:0] raddr, input logic [31:0] rd,
                     input logic v, input logic [23:0] d,
                     input logic i);
    vec_t e;
    e.wr = wr; e.addr = addr; e.wd = wd; e.pop = p;
    e.raddr = raddr; e.exp_rd = rd; e.exp_valid = v;
    e.exp_data = d; e.exp_irq = i;
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic wr, input logic [1:0] addr,
                     input logic [31:0] wd, input logic p);
    write = wr; address = addr; writedata = wd; pop = p;
    @(posedge clk);
    #1;
    write = 1'b0; pop = 1'b0;
  endtask

  task automatic stat(output logic [31:0] s);
    address = 2'd1;
    #1;
    s = readdata;
  endtask

  logic [31:0] s;
  logic [23:0] last;

  initial begin
    reset = 1'b1; address = '0; writedata = '0;
    write = 1'b0; read = 1'b0; pop = 1'b0;

    // push FF0000, 00FF00, 0000FF then pop all
    add(1, 0, 32'hFF0000, 0, 1, 32'h101, 1, 24'hFF0000, 0);
    add(1, 0, 32'h00FF00, 0, 1, 32'h201, 1, 24'hFF0000, 0);
    add(1, 0, 32'h0000FF, 0, 1, 32'h301, 1, 24'hFF0000, 0);
    add(0, 0, 32'h0, 1, 1, 32'h201, 1, 24'h00FF00, 0);
    add(0, 0, 32'h0, 1, 1, 32'h101, 1, 24'h0000FF, 0);
    add(0, 0, 32'h0, 1, 1, 32'h000, 0, 24'h0, 0);
    // underrun, clear, push+pop on empty, flush
    add(0, 0, 32'h0, 1, 1, 32'h008, 0, 24'h0, 0);
    add(1, 2, 32'h8, 0, 1, 32'h000, 0, 24'h0, 0);
    add(1, 0, 32'h123456, 1, 1, 32'h109, 1, 24'h123456, 0);
    add(1, 2, 32'h9, 0, 1, 32'h000, 0, 24'h0, 0);
    // threshold 4 (upper bits ignored), irq_en
    add(1, 3, 32'hFFFF_FFE4, 0, 3, 32'h4, 0, 24'h0, 0);
    add(1, 2, 32'h10, 0, 2, 32'h10, 0, 24'h0, 0);
    add(1, 0, 32'h1, 0, 1, 32'h111, 1, 24'h1, 1);
    add(1, 0, 32'h2, 0, 1, 32'h211, 1, 24'h1, 1);
    add(1, 0, 32'h3, 0, 1, 32'h311, 1, 24'h1, 1);
    add(1, 0, 32'h4, 0, 1, 32'h411, 1, 24'h1, 1);
    add(0, 0, 32'h0, 0, 1, 32'h401, 1, 24'h1, 0);
    add(0, 0, 32'h0, 1, 1, 32'h301, 1, 24'h2, 0);
    add(0, 0, 32'h0, 0, 1, 32'h311, 1, 24'h2, 1);
    // flush with concurrent pop, then on empty
    add(1, 2, 32'h11, 1, 1, 32'h010, 0, 24'h0, 1);
    add(1, 2, 32'h11, 1, 1, 32'h010, 0, 24'h0, 1);
    add(1, 2, 32'h0, 0, 1, 32'h010, 0, 24'h0, 1);
    add(0, 0, 32'h0, 0, 1, 32'h000, 0, 24'h0, 0);

    @(posedge clk);
    #1;
    stat(s);
    chk("reset_status", s, 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    #2;

    foreach (tv[i]) begin
      cyc(tv[i].wr, tv[i].addr, tv[i].wd, tv[i].pop);
      address = tv[i].raddr;
      #1;
      chk($sformatf("v%0d_rd", i), readdata, tv[i].exp_rd);
      chk($sformatf("v%0d_valid", i), 32'(valid),
          32'(tv[i].exp_valid));
      chk($sformatf("v%0d_data", i), 32'(data_out),
          32'(tv[i].exp_data));
      chk($sformatf("v%0d_irq", i), 32'(irq),
          32'(tv[i].exp_irq));
    end

    // overflow, threshold above DEPTH
    cyc(1, 3, 32'h1F, 0);
    cyc(1, 2, 32'h10, 0);
    for (int k = 1; k <= 16; k++) cyc(1, 0, 32'(k), 0);
    stat(s);
    chk("full_bit", 32'(s[1]), 32'h1);
    chk("full_count", 32'(s[12:8]), 32'd16);
    chk("full_no_ovf", 32'(s[2]), 32'h0);
    cyc(1, 0, 32'd17, 0);
    stat(s);
    chk("ovf_bit", 32'(s[2]), 32'h1);
    chk("ovf_count", 32'(s[12:8]), 32'd16);
    chk("irq_thr_gt_depth", 32'(irq), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d", k), 32'(data_out), 32'(k));
      cyc(0, 0, 32'h0, 1);
    end
    chk("drain_empty", 32'(valid), 32'h0);
    cyc(1, 2, 32'h14, 0);
    stat(s);
    chk("ovf_clear", 32'(s[2]), 32'h0);
    cyc(1, 2, 32'h0, 0);
    cyc(1, 3, 32'h0, 0);

    // push+pop while full
    for (int k = 0; k < 16; k++) cyc(1, 0, 32'h10 + 32'(k), 0);
    cyc(1, 0, 32'hAA, 1);
    stat(s);
    chk("fullpp_count", 32'(s[12:8]), 32'd16);
    chk("fullpp_ovf", 32'(s[2]), 32'h0);
    chk("fullpp_head", 32'(data_out), 32'h11);
    last = '0;
    for (int k = 0; k < 16; k++) begin
      last = data_out;
      cyc(0, 0, 32'h0, 1);
    end
    chk("fullpp_last", 32'(last), 32'hAA);
    chk("fullpp_empty", 32'(valid), 32'h0);

    // reset mid-stream
    cyc(1, 2, 32'h10, 0);
    for (int k = 0; k < 8; k++) cyc(1, 0, 32'h70 + 32'(k), 0);
    stat(s);
    chk("pre_rst_count", 32'(s[12:8]), 32'd8);
    reset = 1'b1;
    #1;
    stat(s);
    chk("rst_status", s, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    address = 2'd2;
    #1;
    chk("rst_irq_en", readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    cyc(1, 0, 32'h55, 0);
    stat(s);
    chk("post_rst_count", 32'(s[12:8]), 32'd1);
    chk("post_rst_data", 32'(data_out), 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812b_fifo_avalon_interface.md
Name: ws2812b_fifo_avalon_interface

Overview:
Parametrised Avalon-MM slave that buffers pixel words from the host CPU into a DEPTH-entry FIFO and presents them to the WS2812B serializer through a valid/pop handshake. It replaces the single-word pixel buffer. It adds:
- Multi-word buffering with full/empty status and an occupancy count.
- Sticky overflow and underrun error flags.
- A software flush.
- A low-water interrupt, so the CPU can refill in bursts.

Parameters:
- DATA_WIDTH, 24: pixel word width in bits; legal range 1..32.
- DEPTH, 16: FIFO entries; must be a power of two, 2..4096.
- AW, log2(DEPTH): derived localparam, not overridable; pointer width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon register select.
- writedata  in  32  Avalon write data.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe; zero wait states, no side effects.
- readdata  out  32  Avalon read data; combinational from address.
- pop  in  1  serializer consumes the head word this cycle.
- data_out  out  DATA_WIDTH  head word of FIFO.
- valid  out  1  FIFO not empty; data_out meaningful.
- irq  out  1  level interrupt, low-water condition.

Behaviour:
Register map:
- Addr 0, write-only (reads return 0): PUSH. writedata[DATA_WIDTH-1:0] is enqueued.
- Addr 1, read-only: STATUS.
  - [0] valid
  - [1] full
  - [2] overflow (sticky)
  - [3] underrun (sticky)
  - [4] irq
  - [7:5] 0
  - [8+AW:8] count
  - other bits 0
- Addr 2, write-only: CONTROL.
  - bit0 = flush
  - bit2 = clear overflow (W1C)
  - bit3 = clear underrun (W1C)
  - bit4 = irq_en
  - Reads return {27'b0, irq_en, 4'b0}.
- Addr 3, read/write: THRESHOLD[AW:0]; upper bits write-ignored, read 0.

Reset: while reset is high, all of the following hold:
- Pointers and count = 0.
- overflow = 0, underrun = 0.
- irq_en = 0, threshold = 0.
- valid = 0, irq = 0.
- data_out = 0; storage contents don't care, but data_out is gated to 0 when empty.

Reset asserted mid-operation discards all queued words. The first push after deassertion behaves as from empty.

FIFO:
- Storage is a register array indexed by registered write/read pointers (AW bits, natural wrap at DEPTH).
- count is AW+1 bits.
- Latency: a push in cycle N makes the word visible on data_out with valid=1 in cycle N+1 (first-word-fall-through).
- No combinational path exists from writedata/write/address to data_out/valid.
- valid = (count != 0).
- full = (count == DEPTH).
- data_out = head entry when valid, else 0.

Pop:
- pop with valid=1: advances the read pointer; the next word appears in the following cycle.
- pop with valid=0: ignored; sets underrun.

Push:
- Push with full=1 and no accepted pop in the same cycle: word dropped; sets overflow.
- Push and accepted pop in the same cycle:
  - Both take effect; count unchanged.
  - This applies when full (no overflow).
- Push and pop while empty: the pop is an underrun (valid=0 that cycle); the push is accepted; count becomes 1.

Flush:
- Write addr 2 with bit0=1: pointers and count = 0 on that edge.
- A simultaneous pop is discarded and does not set underrun.
- Flush does not clear the sticky flags.
- A CONTROL write also updates irq_en and performs the W1C clears in the same cycle.

Sticky flags:
- Set has priority over a W1C clear in the same cycle.

Interrupt:
- irq = irq_en & (count < threshold), registered (updates one cycle after count/threshold/irq_en change).
- threshold = 0 disables it.
- threshold > DEPTH keeps irq asserted while irq_en=1.

The read strobe has no side effects; readdata is valid in the same cycle as address.

Test Plan:
- Reset, then push 0xFF0000, 0x00FF00, 0x0000FF to addr 0 on consecutive cycles → valid rises the cycle after the first write; data_out = 0xFF0000; STATUS count = 3. Three pops → data_out sequence 0xFF0000, 0x00FF00, 0x0000FF, then valid=0 and data_out=0.
- Push DEPTH+1 words (values 1..17 with DEPTH=16) → full=1 after 16; overflow=1; word 17 dropped. Draining yields 1..16. Write addr 2 = 0x4 → overflow=0.
- With the FIFO full, push 0xAA and pop in the same cycle → count stays 16, overflow=0. The last drained word is 0xAA.
- Pop while empty → underrun=1, count=0. Simultaneous push 0x123456 + pop on empty → count=1, data_out=0x123456.
- threshold=4, irq_en=1, push 3 words → irq=1. Push 4th → irq=0 one cycle later. Pop → irq=1 again.
- Push 5 words, write flush concurrent with pop → next cycle count=0, valid=0, underrun unchanged. Assert reset mid-stream with 8 queued → valid=0, count=0, irq_en=0 immediately.
